// File: rtl/apc_pkg.sv
// Shared widths, saturation limits, FSM states and coefficient bundle for the
// amplitude/phase correction stage.
package apc_pkg;

    localparam int DATA_W     = 12;
    localparam int COEF_W     = 16;
    localparam int COEF_FRAC  = 14;
    localparam int UNITY_GAIN = 16384;
    localparam int SAT_MAX    = 2047;
    localparam int SAT_MIN    = -2048;
    localparam int WIDE_W     = 16;

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        RUN
    } apc_state_t;

    typedef struct packed {
        logic signed [COEF_W-1:0] gain;
        logic signed [COEF_W-1:0] phase;
        logic signed [DATA_W-1:0] off_i;
        logic signed [DATA_W-1:0] off_q;
    } apc_coef_t;

    localparam apc_coef_t COEF_RESET = '{
        gain:  COEF_W'(UNITY_GAIN),
        phase: '0,
        off_i: '0,
        off_q: '0
    };

    function automatic logic is_clip(input logic signed [WIDE_W-1:0] x);
        return (int'(x) > SAT_MAX) || (int'(x) < SAT_MIN);
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [WIDE_W-1:0] x);
        if (int'(x) > SAT_MAX)
            return DATA_W'(SAT_MAX);
        else if (int'(x) < SAT_MIN)
            return DATA_W'(SAT_MIN);
        else
            return x[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/apc_lane.sv
// Four-stage datapath for one I/Q pair: Q' = gain*Q + phase*I with rounding
// and saturation; I is delayed to stay aligned.
module apc_lane
    import apc_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] i_in,
    input  logic signed [DATA_W-1:0] q_in,
    input  logic signed [DATA_W-1:0] off_i,
    input  logic signed [DATA_W-1:0] off_q,
    input  logic signed [COEF_W-1:0] gain,
    input  logic signed [COEF_W-1:0] phase,
    output logic signed [DATA_W-1:0] i_out,
    output logic signed [DATA_W-1:0] q_out,
    output logic                     sat
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int SUM_W  = PROD_W + 1;
    localparam int ROUND  = 1 << (COEF_FRAC - 1);

    logic signed [DATA_W:0]   i_diff, q_diff;
    logic signed [SUM_W-1:0]  sum_rnd;
    logic signed [DATA_W-1:0] i_s1, q_s1, i_s2, i_s3;
    logic signed [PROD_W-1:0] pq_s2, pi_s2;
    logic signed [WIDE_W-1:0] q_s3;
    logic                     clip_s1, clip_s2, clip_s3;

    always_comb begin
        i_diff  = (DATA_W+1)'(i_in) - (DATA_W+1)'(off_i);
        q_diff  = (DATA_W+1)'(q_in) - (DATA_W+1)'(off_q);
        sum_rnd = SUM_W'(pq_s2) + SUM_W'(pi_s2) + SUM_W'(ROUND);
        // Clipping in the offset stage counts as pair saturation too.
        sat     = is_clip(q_s3) | clip_s3;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_s1    <= '0;
            q_s1    <= '0;
            clip_s1 <= 1'b0;
            i_s2    <= '0;
            pq_s2   <= '0;
            pi_s2   <= '0;
            clip_s2 <= 1'b0;
            i_s3    <= '0;
            q_s3    <= '0;
            clip_s3 <= 1'b0;
            i_out   <= '0;
            q_out   <= '0;
        end else begin
            i_s1    <= sat_data(WIDE_W'(i_diff));
            q_s1    <= sat_data(WIDE_W'(q_diff));
            clip_s1 <= is_clip(WIDE_W'(i_diff)) | is_clip(WIDE_W'(q_diff));
            i_s2    <= i_s1;
            pq_s2   <= PROD_W'(q_s1) * PROD_W'(gain);
            pi_s2   <= PROD_W'(i_s1) * PROD_W'(phase);
            clip_s2 <= clip_s1;
            i_s3    <= i_s2;
            q_s3    <= WIDE_W'(sum_rnd >>> COEF_FRAC);
            clip_s3 <= clip_s2;
            i_out   <= i_s3;
            q_out   <= sat_data(q_s3);
        end
    end

endmodule

// File: rtl/ap_correct_iq.sv
// Amplitude/phase imbalance correction for two I/Q pairs in the rd_clk domain.
// Optional per-lane DC offset removal: define APC_DC_OFFSET_EN.
module ap_correct_iq
    import apc_pkg::*;
#(
    parameter int BRAM_LAT  = 2,
    parameter int FRAME_LEN = 8192
) (
    input  logic                     rd_clk,
    input  logic                     rd_rst_n,
    input  logic signed [DATA_W-1:0] fifo_to_apcorrect_data_i0,
    input  logic signed [DATA_W-1:0] fifo_to_apcorrect_data_i1,
    input  logic signed [DATA_W-1:0] fifo_to_apcorrect_data_q0,
    input  logic signed [DATA_W-1:0] fifo_to_apcorrect_data_q1,
    input  logic                     ap_correct_valid,
    input  logic signed [COEF_W-1:0] coef_gain_q0,
    input  logic signed [COEF_W-1:0] coef_gain_q1,
    input  logic signed [COEF_W-1:0] coef_phase_q0,
    input  logic signed [COEF_W-1:0] coef_phase_q1,
    input  logic                     coef_load,
    input  logic                     sat_clr,
    output logic signed [DATA_W-1:0] corr_data_i0,
    output logic signed [DATA_W-1:0] corr_data_i1,
    output logic signed [DATA_W-1:0] corr_data_q0,
    output logic signed [DATA_W-1:0] corr_data_q1,
    output logic                     corr_valid,
    output logic                     frame_start,
    output logic [1:0]               sat_flag
`ifdef APC_DC_OFFSET_EN
    ,
    input  logic signed [DATA_W-1:0] dc_off_i0,
    input  logic signed [DATA_W-1:0] dc_off_i1,
    input  logic signed [DATA_W-1:0] dc_off_q0,
    input  logic signed [DATA_W-1:0] dc_off_q1
`endif
);

    localparam int CNT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int WARM_W = (BRAM_LAT > 1) ? $clog2(BRAM_LAT) : 1;

    apc_state_t          state, state_nxt;
    logic [WARM_W-1:0]   warm_cnt;
    logic [CNT_W-1:0]    samp_cnt;
    logic                accept, frame_acc, warm_done;
    logic [3:0]          vld_pipe, sof_pipe;
    apc_coef_t [1:0]     coef_in, coef_shd, coef_act, coef_nxt;
    logic                load_pend, pend_nxt;
    logic [1:0]          lane_sat, sat_hit;

    assign accept    = (state == RUN) && ap_correct_valid;
    assign frame_acc = accept && (samp_cnt == '0);
    assign warm_done = (int'(warm_cnt) == BRAM_LAT - 1);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ap_correct_valid) state_nxt = (BRAM_LAT == 0) ? RUN : WARMUP;
            WARMUP:  if (!ap_correct_valid) state_nxt = IDLE;
                     else if (warm_done)    state_nxt = RUN;
            RUN:     if (!ap_correct_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        coef_in          = {COEF_RESET, COEF_RESET};
        coef_in[0].gain  = coef_gain_q0;
        coef_in[0].phase = coef_phase_q0;
        coef_in[1].gain  = coef_gain_q1;
        coef_in[1].phase = coef_phase_q1;
`ifdef APC_DC_OFFSET_EN
        coef_in[0].off_i = dc_off_i0;
        coef_in[0].off_q = dc_off_q0;
        coef_in[1].off_i = dc_off_i1;
        coef_in[1].off_q = dc_off_q1;
`endif
    end

    // In RUN the swap lands with the samp_cnt = 0 sample; a load on that very
    // cycle bypasses the shadow so it takes effect at the same boundary.
    always_comb begin
        coef_nxt = coef_act;
        pend_nxt = load_pend;
        if (state != RUN) begin
            if (load_pend) begin
                coef_nxt = coef_shd;
                pend_nxt = 1'b0;
            end
        end else if (frame_acc) begin
            if (coef_load)
                coef_nxt = coef_in;
            else if (load_pend)
                coef_nxt = coef_shd;
            pend_nxt = 1'b0;
        end
        if (coef_load && !frame_acc)
            pend_nxt = 1'b1;
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state     <= IDLE;
            warm_cnt  <= '0;
            samp_cnt  <= '0;
            vld_pipe  <= '0;
            sof_pipe  <= '0;
            coef_shd  <= {COEF_RESET, COEF_RESET};
            coef_act  <= {COEF_RESET, COEF_RESET};
            load_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            warm_cnt  <= (state == WARMUP) ? warm_cnt + WARM_W'(1) : '0;
            if (state != RUN)
                samp_cnt <= '0;
            else if (accept)
                samp_cnt <= (samp_cnt == CNT_W'(FRAME_LEN - 1)) ? '0 : samp_cnt + CNT_W'(1);
            // Dropping ap_correct_valid flushes everything in flight.
            if (!ap_correct_valid) begin
                vld_pipe <= '0;
                sof_pipe <= '0;
            end else begin
                vld_pipe <= {vld_pipe[2:0], accept};
                sof_pipe <= {sof_pipe[2:0], frame_acc};
            end
            if (coef_load)
                coef_shd <= coef_in;
            coef_act  <= coef_nxt;
            load_pend <= pend_nxt;
        end
    end

    assign sat_hit = lane_sat & {2{vld_pipe[2] & ap_correct_valid}};

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            sat_flag <= '0;
        end else begin
            for (int unsigned k = 0; k < 2; k++) begin
                if (sat_hit[k])
                    sat_flag[k] <= 1'b1;
                else if (sat_clr)
                    sat_flag[k] <= 1'b0;
            end
        end
    end

    assign corr_valid  = vld_pipe[3];
    assign frame_start = sof_pipe[3];

    apc_lane u_lane0 (
        .clk   (rd_clk),
        .rst_n (rd_rst_n),
        .i_in  (fifo_to_apcorrect_data_i0),
        .q_in  (fifo_to_apcorrect_data_q0),
        .off_i (coef_nxt[0].off_i),
        .off_q (coef_nxt[0].off_q),
        .gain  (coef_act[0].gain),
        .phase (coef_act[0].phase),
        .i_out (corr_data_i0),
        .q_out (corr_data_q0),
        .sat   (lane_sat[0])
    );

    apc_lane u_lane1 (
        .clk   (rd_clk),
        .rst_n (rd_rst_n),
        .i_in  (fifo_to_apcorrect_data_i1),
        .q_in  (fifo_to_apcorrect_data_q1),
        .off_i (coef_nxt[1].off_i),
        .off_q (coef_nxt[1].off_q),
        .gain  (coef_act[1].gain),
        .phase (coef_act[1].phase),
        .i_out (corr_data_i1),
        .q_out (corr_data_q1),
        .sat   (lane_sat[1])
    );

endmodule

// File: tb/tb_ap_correct_iq.sv
// Directed bench for ap_correct_iq: warmup/latency, gain rounding, saturation,
// frame-aligned coefficient updates and valid-drop flush.
module tb_ap_correct_iq;

    logic               rd_clk = 1'b0;
    logic               rd_rst_n;
    logic signed [11:0] d_i0, d_i1, d_q0, d_q1;
    logic               ap_correct_valid;
    logic signed [15:0] gain_q0, gain_q1, phase_q0, phase_q1;
    logic               coef_load, sat_clr;
    logic signed [11:0] c_i0, c_i1, c_q0, c_q1;
    logic               corr_valid, frame_start;
    logic [1:0]         sat_flag;
`ifdef APC_DC_OFFSET_EN
    logic signed [11:0] off_i0 = '0, off_i1 = '0, off_q0 = '0, off_q1 = '0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 rd_clk = ~rd_clk;

    ap_correct_iq #(.BRAM_LAT(2), .FRAME_LEN(8192)) dut (
        .rd_clk                    (rd_clk),
        .rd_rst_n                  (rd_rst_n),
        .fifo_to_apcorrect_data_i0 (d_i0),
        .fifo_to_apcorrect_data_i1 (d_i1),
        .fifo_to_apcorrect_data_q0 (d_q0),
        .fifo_to_apcorrect_data_q1 (d_q1),
        .ap_correct_valid          (ap_correct_valid),
        .coef_gain_q0              (gain_q0),
        .coef_gain_q1              (gain_q1),
        .coef_phase_q0             (phase_q0),
        .coef_phase_q1             (phase_q1),
        .coef_load                 (coef_load),
        .sat_clr                   (sat_clr),
        .corr_data_i0              (c_i0),
        .corr_data_i1              (c_i1),
        .corr_data_q0              (c_q0),
        .corr_data_q1              (c_q1),
        .corr_valid                (corr_valid),
        .frame_start               (frame_start),
        .sat_flag                  (sat_flag)
`ifdef APC_DC_OFFSET_EN
        ,
        .dc_off_i0                 (off_i0),
        .dc_off_i1                 (off_i1),
        .dc_off_q0                 (off_q0),
        .dc_off_q1                 (off_q1)
`endif
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic load_coefs(input logic signed [15:0] g0, input logic signed [15:0] p0);
        gain_q0   = g0;
        phase_q0  = p0;
        coef_load = 1'b1;
        tick();
        coef_load = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        rd_rst_n = 1'b0;
        ap_correct_valid = 1'b0;
        {d_i0, d_i1, d_q0, d_q1} = '0;
        gain_q0 = 16'sd16384; gain_q1 = 16'sd16384;
        phase_q0 = '0; phase_q1 = '0;
        coef_load = 1'b0; sat_clr = 1'b0;
        repeat (3) tick();
        chk("rst_valid", corr_valid, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_sat", sat_flag, 0);
        chk("rst_q0", c_q0, 0);
        chk("rst_i1", c_i1, 0);
        rd_rst_n = 1'b1;
        repeat (2) tick();

        // Ramp at unity: cycle 0 IDLE, 1-2 WARMUP, first accepted at 3 -> out at 7.
        for (int j = 0; j < 70; j++) begin
            ap_correct_valid = !(j >= 53 && j <= 60);
            d_i0 = 12'(-2048 + j); d_q0 = 12'(-2048 + j);
            d_i1 = 12'(2047 - j);  d_q1 = 12'(2047 - j);
            if (j == 6) chk("A_pre_valid", corr_valid, 0);
            if (j == 7) begin
                chk("A_first_valid", corr_valid, 1);
                chk("A_first_fs", frame_start, 1);
                chk("A_first_q0", c_q0, -2045);
                chk("A_first_i0", c_i0, -2045);
                chk("A_first_q1", c_q1, 2044);
                chk("A_first_i1", c_i1, 2044);
            end
            if (j == 8) begin
                chk("A_second_fs", frame_start, 0);
                chk("A_second_q0", c_q0, -2044);
            end
            if (j == 53) begin
                chk("A_last_valid", corr_valid, 1);
                chk("A_last_q0", c_q0, -1999);
            end
            if (j >= 54 && j <= 67) chk("A_drop_valid", corr_valid, 0);
            if (j == 68) begin
                chk("A_restart_valid", corr_valid, 1);
                chk("A_restart_fs", frame_start, 1);
                chk("A_restart_q0", c_q0, -1984);
            end
            tick();
        end
        ap_correct_valid = 1'b0;
        repeat (3) tick();

        // Half gain on q0: 1001 -> 501, -3 -> -1; pair 1 stays unity.
        load_coefs(16'sd8192, 16'sd0);
        for (int j = 0; j < 10; j++) begin
            ap_correct_valid = 1'b1;
            d_i0 = '0; d_i1 = '0;
            d_q0 = (j <= 3) ? 12'sd1001 : -12'sd3;
            d_q1 = 12'sd1001;
            if (j == 7) begin
                chk("B_q0_501", c_q0, 501);
                chk("B_q1_unity", c_q1, 1001);
                chk("B_fs", frame_start, 1);
            end
            if (j == 8) chk("B_q0_neg", c_q0, -1);
            tick();
        end
        ap_correct_valid = 1'b0;
        repeat (3) tick();

        // Phase 0.5 with full-scale I and Q clips q0; set beats a same-cycle clear.
        load_coefs(16'sd16384, 16'sd8192);
        for (int j = 0; j < 11; j++) begin
            ap_correct_valid = (j < 10);
            d_i0 = 12'sd2047; d_q0 = 12'sd2047;
            d_i1 = 12'sd100;  d_q1 = 12'sd100;
            sat_clr = (j == 8);
            if (j == 6) chk("C_sat_before", sat_flag, 0);
            if (j == 7) begin
                chk("C_q0_clip", c_q0, 2047);
                chk("C_sat_set", sat_flag, 1);
                chk("C_q1_pass", c_q1, 100);
            end
            if (j == 9) chk("C_set_wins", sat_flag, 1);
            tick();
        end
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        chk("C_sat_cleared", sat_flag, 0);
        repeat (3) tick();

        // Mid-frame load waits for the next frame; a load at samp_cnt 0 is immediate.
        load_coefs(16'sd16384, 16'sd0);
        for (int j = 0; j < 16393; j++) begin
            ap_correct_valid = 1'b1;
            d_i0 = '0; d_i1 = '0; d_q1 = '0;
            d_q0 = 12'sd1000;
            coef_load = (j == 103) || (j == 16387);
            if (j == 103)   gain_q0 = 16'sd8192;
            if (j == 16387) gain_q0 = 16'sd16384;
            if (j == 7)     chk("D_fs0", frame_start, 1);
            if (j == 108)   chk("D_after_load_old", c_q0, 1000);
            if (j == 8198) begin
                chk("D_frame_end_old", c_q0, 1000);
                chk("D_frame_end_fs", frame_start, 0);
            end
            if (j == 8199) begin
                chk("D_boundary_new", c_q0, 500);
                chk("D_boundary_fs", frame_start, 1);
            end
            if (j == 16390) chk("D_coinc_before", c_q0, 500);
            if (j == 16391) begin
                chk("D_coinc_new", c_q0, 1000);
                chk("D_coinc_fs", frame_start, 1);
            end
            tick();
        end
        coef_load = 1'b0;
        ap_correct_valid = 1'b0;
        repeat (2) tick();
        chk("E_idle_valid", corr_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
